// File: rtl/example_if_pkg.sv
// Shared types and constants for the example_if serial family.
// Line levels and the frame state encoding live here so the receiver can match them.
package example_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/example_if_bit_timer.sv
// Bit-period counter: wraps 0..CLKS_PER_BIT-1 while enabled, tick on the last cycle.
// tick_next looks one cycle ahead so callers can register period-end outputs.
module example_if_bit_timer
    import example_if_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic tick_next
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick      = enable && (cnt == LAST);
    assign tick_next = (cnt_d == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/example_if_serial_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits MSB first, stop bit.
// data_out, busy and done are registered from the next-state values.
module example_if_serial_tx
    import example_if_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             busy,
    output logic             done
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_e        state;
    tx_state_e        state_d;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_d;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_d;
    logic             tick;
    logic             tick_next;
    logic             accept;
    logic             data_out_d;
    logic             busy_d;
    logic             done_d;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    example_if_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == ST_IDLE),
        .enable   (state != ST_IDLE),
        .tick     (tick),
        .tick_next(tick_next)
    );

    always_comb begin
        state_d   = state;
        shift_d   = shift_reg;
        bit_cnt_d = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_reg << 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output levels follow the state we are about to enter, keeping them registered.
    always_comb begin
        data_out_d = IDLE_LEVEL;
        case (state_d)
            ST_START: data_out_d = START_LEVEL;
            ST_DATA:  data_out_d = shift_d[WIDTH-1];
            ST_STOP:  data_out_d = STOP_LEVEL;
            default:  data_out_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && tick_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            data_out  <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            shift_reg <= shift_d;
            bit_cnt   <= bit_cnt_d;
            data_out  <= data_out_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_example_if_serial_tx.sv
// Directed bench for example_if_serial_tx across three parameter sets.
// Expected bit streams are hand-written frame vectors, expanded per bit period.
module tb_example_if_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] a_in_data, b_in_data;
    logic       c_in_data;
    logic       a_in_valid, b_in_valid, c_in_valid;
    logic       a_in_ready, b_in_ready, c_in_ready;
    logic       a_data_out, b_data_out, c_data_out;
    logic       a_busy, b_busy, c_busy;
    logic       a_done, b_done, c_done;

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;

    logic o_data, o_busy, o_done, o_ready;

    example_if_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .data_out(a_data_out), .busy(a_busy), .done(a_done)
    );

    example_if_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .data_out(b_data_out), .busy(b_busy), .done(b_done)
    );

    example_if_serial_tx #(.WIDTH(1), .CLKS_PER_BIT(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .data_out(c_data_out), .busy(c_busy), .done(c_done)
    );

    always_comb begin
        case (cur)
            1: begin o_data = b_data_out; o_busy = b_busy; o_done = b_done; o_ready = b_in_ready; end
            2: begin o_data = c_data_out; o_busy = c_busy; o_done = c_done; o_ready = c_in_ready; end
            default: begin o_data = a_data_out; o_busy = a_busy; o_done = a_done; o_ready = a_in_ready; end
        endcase
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [3:0] d);
        case (sel)
            1: begin b_in_valid = v; b_in_data = d; end
            2: begin c_in_valid = v; c_in_data = d[0]; end
            default: begin a_in_valid = v; a_in_data = d; end
        endcase
    endtask

    // Entered just after a rising edge with the DUT idle; returns likewise.
    // bits holds the w+2 frame bits right-aligned, first bit on the line at the top.
    task automatic run_frame(input int sel, input logic [3:0] word, input int w, input int c,
                             input logic [5:0] bits, input bit glitch, input string tag);
        int nb  = w + 2;
        int len = nb * c;
        int bi;
        cur = sel;
        drive(sel, 1'b1, word);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~word);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            bi = (k - 1) / c;
            check({tag, "_data"},  o_data,  bits[nb-1-bi]);
            check({tag, "_done"},  o_done,  (k == len));
            check({tag, "_busy"},  o_busy,  1'b1);
            check({tag, "_ready"}, o_ready, 1'b0);
            @(posedge clk); #1;
            if (glitch) drive(sel, (k >= c && k < 3 * c), 4'b0000);
        end
        @(negedge clk);
        check({tag, "_end_ready"}, o_ready, 1'b1);
        check({tag, "_end_busy"},  o_busy,  1'b0);
        check({tag, "_end_done"},  o_done,  1'b0);
        check({tag, "_end_data"},  o_data,  1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] b_exp_data, b_exp_busy, b_exp_done;

        rst_n = 1'b0;
        drive(0, 1'b0, 4'b0000);
        drive(1, 1'b0, 4'b0000);
        drive(2, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            cur = s;
            #1;
            check("rst_data", o_data, 1'b1);
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
            check("rst_ready", o_ready, 1'b1);
        end
        rst_n = 1'b1;

        // Idle with unknown data and no valid.
        cur = 0;
        a_in_data = 4'bxxxx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_data", o_data, 1'b1);
            check("idle_ready", o_ready, 1'b1);
            check("idle_busy", o_busy, 1'b0);
            check("idle_done", o_done, 1'b0);
        end
        @(posedge clk); #1;

        // 1010 -> 0,1,0,1,0,1
        run_frame(0, 4'b1010, 4, 4, 6'b010101, 1'b0, "f1010");

        // 0111 with a 0000 offered mid-frame -> 0,0,1,1,1,1 and nothing after.
        run_frame(0, 4'b0111, 4, 4, 6'b001111, 1'b1, "f0111");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_second_busy", o_busy, 1'b0);
            check("no_second_data", o_data, 1'b1);
        end
        @(posedge clk); #1;

        // Reset during data bit 2 of 1100 (cycles T+13..T+16).
        cur = 0;
        drive(0, 1'b1, 4'b1100);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'b0000);
        repeat (13) @(posedge clk);
        #1;
        check("pre_rst_data", o_data, 1'b0);
        check("pre_rst_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_data", o_data, 1'b1);
        check("async_rst_busy", o_busy, 1'b0);
        check("async_rst_done", o_done, 1'b0);
        check("async_rst_ready", o_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("post_rst_done", o_done, 1'b0);
            check("post_rst_busy", o_busy, 1'b0);
        end
        @(posedge clk); #1;
        run_frame(0, 4'b0001, 4, 4, 6'b000011, 1'b0, "f0001");

        // CLKS_PER_BIT=1, back-to-back words with valid held high.
        cur = 1;
        b_exp_data = 13'b0100111001101;
        b_exp_busy = 13'b1111110111111;
        b_exp_done = 13'b0000010000001;
        drive(1, 1'b1, 4'b1001);
        @(posedge clk); #1;
        drive(1, 1'b1, 4'b0110);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check("b2b_data",  o_data,  b_exp_data[13-k]);
            check("b2b_busy",  o_busy,  b_exp_busy[13-k]);
            check("b2b_done",  o_done,  b_exp_done[13-k]);
            check("b2b_ready", o_ready, ~b_exp_busy[13-k]);
            @(posedge clk); #1;
            if (k == 7) drive(1, 1'b0, 4'b0000);
        end
        @(negedge clk);
        check("b2b_end_ready", o_ready, 1'b1);
        check("b2b_end_busy", o_busy, 1'b0);
        @(posedge clk); #1;

        // WIDTH=1, CLKS_PER_BIT=3, data 1 -> 0,0,0,1,1,1,1,1,1
        run_frame(2, 4'b0001, 1, 3, 6'b000011, 1'b0, "w1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
